// File: rtl/mem_arbiter_pkg.sv
// Shared types, defaults and helpers for the instruction/load-store memory arbiter.
package mem_arbiter_pkg;

    // Default word-address width of the single-port memory and the matching byte-address width.
    localparam int addr_dflt_p      = 8;
    localparam int byte_addr_dflt_p = addr_dflt_p + 2;

    // Bit positions of the two requesters inside the request/grant vectors of rr_arbiter2.
    localparam int req_ls_idx = 0;
    localparam int req_if_idx = 1;

    // Width of the saturating contention counter and its ceiling.
    localparam int             cnt_w_p   = 16;
    localparam logic [15:0]    cnt_max_p = 16'hFFFF;

    // Which requester owns the response that appears in the cycle after a grant.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } t_mem_owner;

    // Round-robin pointer: the requester that wins the next contended cycle.
    typedef enum logic {
        PRIO_LS = 1'b0,
        PRIO_IF = 1'b1
    } t_prio;

    // A byte address is misaligned for a word access when its two low bits are not zero.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, the loser of a grant wins the next contended cycle.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    t_prio prio_q;
    t_prio prio_d;

    // Priority pointer register; reset prefers load/store.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prio_q <= PRIO_LS;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Grant selection and pointer update; nothing is granted while reset is asserted.
    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        if (rstn_i) begin
            unique case (req_i)
                2'b01:   gnt_o[req_ls_idx] = 1'b1;
                2'b10:   gnt_o[req_if_idx] = 1'b1;
                2'b11: begin
                    if (prio_q == PRIO_IF) begin
                        gnt_o[req_if_idx] = 1'b1;
                    end else begin
                        gnt_o[req_ls_idx] = 1'b1;
                    end
                end
                default: gnt_o = 2'b00;
            endcase
        end
        if (gnt_o[req_ls_idx]) begin
            prio_d = PRIO_IF;
        end else if (gnt_o[req_if_idx]) begin
            prio_d = PRIO_LS;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port word memory between instruction fetch and load/store,
// maps byte addresses to word addresses, routes responses and counts contention.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int addr_p      = addr_dflt_p,
    parameter int byte_addr_p = addr_p + 2
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,

    input  logic                   if_req_valid_i,
    output logic                   if_req_ready_o,
    input  logic [byte_addr_p-1:0] if_addr_i,
    output logic                   if_rsp_valid_o,
    output logic [31:0]            if_rsp_data_o,
    output logic                   if_rsp_err_o,

    input  logic                   ls_req_valid_i,
    output logic                   ls_req_ready_o,
    input  logic [byte_addr_p-1:0] ls_addr_i,
    input  logic                   ls_wr_i,
    input  logic [31:0]            ls_wdata_i,
    output logic                   ls_rsp_valid_o,
    output logic [31:0]            ls_rsp_data_o,
    output logic                   ls_rsp_err_o,

    output logic [addr_p-1:0]      mem_addr_o,
    output logic                   mem_rd_en_o,
    output logic                   mem_wr_en_o,
    output logic [31:0]            mem_wdata_o,
    input  logic [31:0]            mem_rdata_i,

    output logic [cnt_w_p-1:0]     conflict_cnt_o
);

    logic [1:0]             req;
    logic [1:0]             gnt;
    logic                   gnt_if;
    logic                   gnt_ls;
    logic [byte_addr_p-1:0] sel_addr;
    logic                   sel_misaligned;
    logic                   rd_access;
    logic                   wr_access;

    t_mem_owner             own_q;
    t_mem_owner             own_d;
    logic                   err_q;
    logic                   err_d;
    logic                   rd_q;
    logic                   rd_d;
    logic [cnt_w_p-1:0]     cnt_q;
    logic [cnt_w_p-1:0]     cnt_d;
    logic [31:0]            rsp_data;

    assign req[req_ls_idx] = ls_req_valid_i;
    assign req[req_if_idx] = if_req_valid_i;

    rr_arbiter2 u_rr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req_i  (req),
        .gnt_o  (gnt)
    );

    assign gnt_ls         = gnt[req_ls_idx];
    assign gnt_if         = gnt[req_if_idx];
    assign if_req_ready_o = gnt_if;
    assign ls_req_ready_o = gnt_ls;

    // Memory-side request: misaligned grants are accepted but never reach the memory,
    // and the address/data buses are parked at zero whenever no enable is active.
    always_comb begin
        sel_addr       = gnt_if ? if_addr_i : ls_addr_i;
        sel_misaligned = is_misaligned(sel_addr[1:0]);
        rd_access      = (gnt_if || (gnt_ls && !ls_wr_i)) && !sel_misaligned;
        wr_access      = gnt_ls && ls_wr_i && !sel_misaligned;
        mem_rd_en_o    = rd_access;
        mem_wr_en_o    = wr_access;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        if (rd_access || wr_access) begin
            mem_addr_o = sel_addr[byte_addr_p-1:2];
        end
        if (wr_access) begin
            mem_wdata_o = ls_wdata_i;
        end
    end

    // Capture who was granted this cycle so the response can be steered next cycle.
    always_comb begin
        own_d = OWN_NONE;
        err_d = 1'b0;
        rd_d  = 1'b0;
        if (gnt_if) begin
            own_d = OWN_IF;
        end else if (gnt_ls) begin
            own_d = OWN_LS;
        end
        if (gnt_if || gnt_ls) begin
            err_d = sel_misaligned;
        end
        rd_d = rd_access;
    end

    // Response-owner registers; reset drops any response still in flight.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            own_q <= OWN_NONE;
            err_q <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            own_q <= own_d;
            err_q <= err_d;
            rd_q  <= rd_d;
        end
    end

    // Response steering: only an aligned read carries memory data, everything else returns zero.
    always_comb begin
        rsp_data       = rd_q ? mem_rdata_i : 32'h0;
        if_rsp_valid_o = (own_q == OWN_IF);
        ls_rsp_valid_o = (own_q == OWN_LS);
        if_rsp_err_o   = (own_q == OWN_IF) && err_q;
        ls_rsp_err_o   = (own_q == OWN_LS) && err_q;
        if_rsp_data_o  = (own_q == OWN_IF) ? rsp_data : 32'h0;
        ls_rsp_data_o  = (own_q == OWN_LS) ? rsp_data : 32'h0;
    end

    // Contention counter next value: one step per cycle with both requesters valid, sticking at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (if_req_valid_i && ls_req_valid_i && (cnt_q != cnt_max_p)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Contention counter register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural single-port memory.
module tb_mem_arbiter;

    logic        clk;
    logic        rstn;

    logic        if_req_valid;
    logic        if_req_ready;
    logic [9:0]  if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;

    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [9:0]  ls_addr;
    logic        ls_wr;
    logic [31:0] ls_wdata;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic        ls_rsp_err;

    logic [7:0]  mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] conflict_cnt;

    logic [31:0] mem_array [256];

    int check_count;
    int error_count;

    mem_arbiter #(
        .addr_p      (8),
        .byte_addr_p (10)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .if_req_valid_i (if_req_valid),
        .if_req_ready_o (if_req_ready),
        .if_addr_i      (if_addr),
        .if_rsp_valid_o (if_rsp_valid),
        .if_rsp_data_o  (if_rsp_data),
        .if_rsp_err_o   (if_rsp_err),
        .ls_req_valid_i (ls_req_valid),
        .ls_req_ready_o (ls_req_ready),
        .ls_addr_i      (ls_addr),
        .ls_wr_i        (ls_wr),
        .ls_wdata_i     (ls_wdata),
        .ls_rsp_valid_o (ls_rsp_valid),
        .ls_rsp_data_o  (ls_rsp_data),
        .ls_rsp_err_o   (ls_rsp_err),
        .mem_addr_o     (mem_addr),
        .mem_rd_en_o    (mem_rd_en),
        .mem_wr_en_o    (mem_wr_en),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .conflict_cnt_o (conflict_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural memory: word i preloaded with 0xA500_0000 | i, read data registered one cycle.
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_array[i] = 32'hA500_0000 | i;
        end
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem_array[mem_addr] <= mem_wdata;
        end
        if (mem_rd_en) begin
            mem_rdata <= mem_array[mem_addr];
        end
    end

    // Compare one observed value with its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of requests at the falling edge and let combinational outputs settle.
    task automatic applyStimulus(input logic if_v, input logic [9:0] if_a,
                                 input logic ls_v, input logic [9:0] ls_a,
                                 input logic wr, input logic [31:0] wd);
        @(negedge clk);
        if_req_valid = if_v;
        if_addr      = if_a;
        ls_req_valid = ls_v;
        ls_addr      = ls_a;
        ls_wr        = wr;
        ls_wdata     = wd;
        #1;
    endtask

    // Move just past the next rising edge, where registered responses are visible.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one rising edge with requests idle.
    task automatic resetDut();
        @(negedge clk);
        rstn         = 1'b0;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic grant_ls;
        check_count  = 0;
        error_count  = 0;
        mem_rdata    = 32'h0;
        rstn         = 1'b0;
        if_req_valid = 1'b1;
        if_addr      = 10'h040;
        ls_req_valid = 1'b1;
        ls_addr      = 10'h010;
        ls_wr        = 1'b0;
        ls_wdata     = 32'h0;

        // Reset state: readies and enables forced low even with both requesters valid.
        #3;
        checkOutput("rst_if_ready", if_req_ready, 0);
        checkOutput("rst_ls_ready", ls_req_ready, 0);
        checkOutput("rst_rd_en", mem_rd_en, 0);
        checkOutput("rst_wr_en", mem_wr_en, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_if_rsp_valid", if_rsp_valid, 0);
        checkOutput("rst_ls_rsp_valid", ls_rsp_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("rst_conflict_cnt", conflict_cnt, 0);
        @(negedge clk);
        rstn         = 1'b1;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;

        // Lone LS read of byte 0x010 -> word 0x04.
        applyStimulus(0, 10'h000, 1, 10'h010, 0, 32'h0);
        checkOutput("ls_rd_ready", ls_req_ready, 1);
        checkOutput("ls_rd_if_ready", if_req_ready, 0);
        checkOutput("ls_rd_mem_addr", mem_addr, 8'h04);
        checkOutput("ls_rd_rd_en", mem_rd_en, 1);
        checkOutput("ls_rd_wr_en", mem_wr_en, 0);
        nextCycle();
        checkOutput("ls_rd_rsp_valid", ls_rsp_valid, 1);
        checkOutput("ls_rd_rsp_data", ls_rsp_data, 32'hA500_0004);
        checkOutput("ls_rd_rsp_err", ls_rsp_err, 0);
        checkOutput("ls_rd_if_rsp_valid", if_rsp_valid, 0);

        // Both valid for four cycles from reset: LS, IF, LS, IF.
        resetDut();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 10'h040, 1, 10'h080, 0, 32'h0);
            grant_ls = ((k % 2) == 0);
            checkOutput("rr_ls_ready", ls_req_ready, grant_ls);
            checkOutput("rr_if_ready", if_req_ready, !grant_ls);
            checkOutput("rr_mem_addr", mem_addr, grant_ls ? 8'h20 : 8'h10);
            nextCycle();
            checkOutput("rr_ls_rsp_valid", ls_rsp_valid, grant_ls);
            checkOutput("rr_if_rsp_valid", if_rsp_valid, !grant_ls);
            checkOutput("rr_ls_rsp_data", ls_rsp_data, grant_ls ? 32'hA500_0020 : 32'h0);
            checkOutput("rr_if_rsp_data", if_rsp_data, grant_ls ? 32'h0 : 32'hA500_0010);
        end
        applyStimulus(0, 10'h000, 0, 10'h000, 0, 32'h0);
        checkOutput("rr_conflict_cnt", conflict_cnt, 4);
        checkOutput("rr_idle_rd_en", mem_rd_en, 0);

        // LS write 0xDEADBEEF to byte 0x020, then IF reads it back.
        applyStimulus(0, 10'h000, 1, 10'h020, 1, 32'hDEAD_BEEF);
        checkOutput("wr_wr_en", mem_wr_en, 1);
        checkOutput("wr_rd_en", mem_rd_en, 0);
        checkOutput("wr_mem_addr", mem_addr, 8'h08);
        checkOutput("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        nextCycle();
        checkOutput("wr_ack_valid", ls_rsp_valid, 1);
        checkOutput("wr_ack_data", ls_rsp_data, 0);
        checkOutput("wr_ack_err", ls_rsp_err, 0);
        applyStimulus(1, 10'h020, 0, 10'h000, 0, 32'h0);
        checkOutput("if_rd_ready", if_req_ready, 1);
        checkOutput("if_rd_mem_addr", mem_addr, 8'h08);
        checkOutput("if_rd_rd_en", mem_rd_en, 1);
        nextCycle();
        checkOutput("if_rd_rsp_valid", if_rsp_valid, 1);
        checkOutput("if_rd_rsp_data", if_rsp_data, 32'hDEAD_BEEF);
        checkOutput("if_rd_ls_rsp_valid", ls_rsp_valid, 0);

        // Misaligned LS write to 0x022: granted, memory untouched, error flagged.
        applyStimulus(0, 10'h000, 1, 10'h022, 1, 32'h1234_5678);
        checkOutput("mis_ready", ls_req_ready, 1);
        checkOutput("mis_wr_en", mem_wr_en, 0);
        checkOutput("mis_rd_en", mem_rd_en, 0);
        checkOutput("mis_mem_addr", mem_addr, 0);
        checkOutput("mis_mem_wdata", mem_wdata, 0);
        nextCycle();
        checkOutput("mis_rsp_valid", ls_rsp_valid, 1);
        checkOutput("mis_rsp_err", ls_rsp_err, 1);
        checkOutput("mis_rsp_data", ls_rsp_data, 0);
        applyStimulus(0, 10'h000, 1, 10'h020, 0, 32'h0);
        nextCycle();
        checkOutput("mis_readback", ls_rsp_data, 32'hDEAD_BEEF);
        checkOutput("mis_readback_err", ls_rsp_err, 0);

        // IF read granted, then reset pulsed before the response is consumed.
        applyStimulus(1, 10'h040, 0, 10'h000, 0, 32'h0);
        checkOutput("rstmid_if_ready", if_req_ready, 1);
        nextCycle();
        checkOutput("rstmid_pending", if_rsp_valid, 1);
        rstn         = 1'b0;
        if_req_valid = 1'b0;
        #1;
        checkOutput("rstmid_dropped", if_rsp_valid, 0);
        #1;
        rstn = 1'b1;
        nextCycle();
        checkOutput("rstmid_after_if", if_rsp_valid, 0);
        checkOutput("rstmid_after_ls", ls_rsp_valid, 0);

        // LS grant moves priority to IF; a reset pulse must bring it back to LS.
        applyStimulus(0, 10'h000, 1, 10'h010, 0, 32'h0);
        nextCycle();
        rstn         = 1'b0;
        ls_req_valid = 1'b0;
        #1;
        checkOutput("prio_rsp_dropped", ls_rsp_valid, 0);
        #1;
        rstn = 1'b1;
        applyStimulus(1, 10'h040, 1, 10'h080, 0, 32'h0);
        checkOutput("prio_ls_wins", ls_req_ready, 1);
        checkOutput("prio_if_loses", if_req_ready, 0);

        // Saturation: 70000 contended cycles pin the counter at 0xFFFF.
        resetDut();
        applyStimulus(1, 10'h040, 1, 10'h080, 0, 32'h0);
        repeat (70000) @(posedge clk);
        applyStimulus(0, 10'h000, 0, 10'h000, 0, 32'h0);
        checkOutput("sat_conflict_cnt", conflict_cnt, 32'h0000_FFFF);
        nextCycle();
        checkOutput("sat_hold", conflict_cnt, 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
